// File: rtl/spram_pwm_player.sv
// Plays 8-bit samples fetched from SPRAM as one PWM period each, and produces the
// period-end strobe that paces the upstream fread loader.
module spram_pwm_player #(
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = 14,
    parameter int PWM_W  = 8,
    parameter int LOOP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              ram_ready,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              pwm_out,
    output logic              pw_end,
    output logic [PWM_W-1:0]  sample,
    output logic              playing,
    output logic              wrap,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(DEPTH - 1);
    localparam logic [PWM_W-1:0]  CNT_MAX      = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0]  CNT_PREFETCH = PWM_W'(2);

    state_t              state_q, state_d;
    logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [PWM_W-1:0]    sample_q, sample_d;
    logic [PWM_W-1:0]    sample_next_q, sample_next_d;
    logic                pwm_out_q, pwm_out_d;
    logic                pw_end_q, pw_end_d;
    logic                playing_q, playing_d;
    logic                wrap_q, wrap_d;
    logic                done_q, done_d;

    logic                go_s;
    logic                pe_s;
    logic                at_last_s;
    logic                prefetch_s;
    logic [ADDR_W-1:0]   addr_inc_s;
    logic                unused_hi_s;

    assign go_s        = ram_ready & enable;
    assign pe_s        = (pwm_cnt_q == CNT_MAX);
    assign at_last_s   = (rd_addr_q == LAST_ADDR);
    assign prefetch_s  = (pwm_cnt_q == CNT_PREFETCH);
    assign addr_inc_s  = at_last_s ? {ADDR_W{1'b0}} : (rd_addr_q + ADDR_W'(1));
    assign unused_hi_s = ^rd_data[15:8];

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pwm_cnt_q     <= {PWM_W{1'b0}};
            rd_addr_q     <= {ADDR_W{1'b0}};
            sample_q      <= {PWM_W{1'b0}};
            sample_next_q <= {PWM_W{1'b0}};
            pwm_out_q     <= 1'b0;
            pw_end_q      <= 1'b0;
            playing_q     <= 1'b0;
            wrap_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pwm_cnt_q     <= pwm_cnt_d;
            rd_addr_q     <= rd_addr_d;
            sample_q      <= sample_d;
            sample_next_q <= sample_next_d;
            pwm_out_q     <= pwm_out_d;
            pw_end_q      <= pw_end_d;
            playing_q     <= playing_d;
            wrap_q        <= wrap_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic; in PLAY, rd_addr==0 only after the pass has wrapped, so a
    // single pass stops once the last word has had its full period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go_s) state_d = ST_ARM;
                else      state_d = ST_IDLE;
            end
            ST_ARM: begin
                if (!go_s)     state_d = ST_IDLE;
                else if (pe_s) state_d = ST_PLAY;
                else           state_d = ST_ARM;
            end
            ST_PLAY: begin
                if (!go_s)                                                 state_d = ST_IDLE;
                else if (pe_s && (LOOP == 0) && (rd_addr_q == {ADDR_W{1'b0}})) state_d = ST_DONE;
                else                                                       state_d = ST_PLAY;
            end
            ST_DONE: begin
                if (!go_s) state_d = ST_IDLE;
                else       state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output decode
    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + PWM_W'(1);
        pw_end_d      = pe_s;
        rd_addr_d     = rd_addr_q;
        sample_d      = sample_q;
        sample_next_d = sample_next_q;
        wrap_d        = 1'b0;
        case (state_q)
            ST_ARM, ST_PLAY: begin
                if (prefetch_s) sample_next_d = PWM_W'(rd_data[7:0]);
                else            sample_next_d = sample_next_q;
                if (state_d == ST_PLAY) begin
                    if (pe_s) begin
                        sample_d  = sample_next_q;
                        rd_addr_d = addr_inc_s;
                        wrap_d    = (state_q == ST_PLAY) && at_last_s;
                    end else begin
                        sample_d  = sample_q;
                        rd_addr_d = rd_addr_q;
                    end
                end else begin
                    sample_d  = {PWM_W{1'b0}};
                    rd_addr_d = {ADDR_W{1'b0}};
                end
            end
            default: begin
                rd_addr_d     = {ADDR_W{1'b0}};
                sample_d      = {PWM_W{1'b0}};
                sample_next_d = {PWM_W{1'b0}};
            end
        endcase
        // Decoding the next state lets an abort silence the pin on the very next clock.
        pwm_out_d = (state_d == ST_PLAY) && (pwm_cnt_q < sample_q);
        playing_d = (state_d == ST_PLAY);
        done_d    = (state_d == ST_DONE);
    end

    assign rd_addr = rd_addr_q;
    assign pwm_out = pwm_out_q;
    assign pw_end  = pw_end_q;
    assign sample  = sample_q;
    assign playing = playing_q;
    assign wrap    = wrap_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spram_pwm_player.sv
// Scoreboarded bench: a looping DEPTH=8 player checked per PWM period, plus a
// single-pass DEPTH=4 player checked for DONE behaviour.
module tb_spram_pwm_player;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_a, rr_a, en_b, rr_b;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [15:0]   rd_data_a, rd_data_b;
    logic          pwm_out_a, pw_end_a, playing_a, wrap_a, done_a;
    logic          pwm_out_b, pw_end_b, playing_b, wrap_b, done_b;
    logic [7:0]    sample_a, sample_b;

    always #5 clk = ~clk;

    spram_pwm_player #(.DEPTH(8), .ADDR_W(AW), .PWM_W(8), .LOOP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .ram_ready(rr_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .pwm_out(pwm_out_a),
        .pw_end(pw_end_a), .sample(sample_a), .playing(playing_a),
        .wrap(wrap_a), .done(done_a)
    );

    spram_pwm_player #(.DEPTH(4), .ADDR_W(AW), .PWM_W(8), .LOOP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .ram_ready(rr_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .pwm_out(pwm_out_b),
        .pw_end(pw_end_b), .sample(sample_b), .playing(playing_b),
        .wrap(wrap_b), .done(done_b)
    );

    function automatic logic [7:0] word_a(input int a);
        case (a)
            5:       return 8'h80;
            6:       return 8'hFF;
            default: return 8'(a);
        endcase
    endfunction

    // SPRAM models with one clock of read latency and junk in the unused high byte
    always @(posedge clk) begin
        rd_data_a <= {8'h5A, word_a(int'(rd_addr_a))};
        rd_data_b <= {8'hA5, rd_addr_b[7:0]};
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    typedef struct {
        logic [7:0]    smp;
        logic [AW-1:0] addr;
        logic          wrp;
    } exp_t;
    exp_t sb_q[$];
    int   wrap_hi = 0;

    task automatic push_periods(input int n);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            e.smp  = word_a((k - 1) % 8);
            e.addr = AW'(k % 8);
            e.wrp  = (k % 8 == 0);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_pe(input int n, output int cycles);
        int seen;
        seen   = 0;
        cycles = 0;
        while (seen < n && cycles < n * 260) begin
            @(negedge clk);
            cycles++;
            if (pw_end_a) seen++;
        end
        if (seen != n) chk("pe_timeout", seen, n);
    endtask

    // Per-period monitor for dut_a: compares each fully played period with the scoreboard
    initial begin
        logic          started, play_all, st_wrap;
        logic [7:0]    st_smp;
        logic [AW-1:0] st_addr;
        int            hi_cnt, hi_first, hi_last, offs;
        exp_t          e;
        started = 1'b0; play_all = 1'b0; st_wrap = 1'b0; st_smp = 8'h00; st_addr = '0;
        hi_cnt = 0; hi_first = -1; hi_last = -1; offs = 0;
        forever begin
            @(negedge clk);
            if (wrap_a) wrap_hi++;
            if (!rst_n) begin
                started = 1'b0;
            end else if (pw_end_a) begin
                if (started && play_all) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("period_sample", st_smp, e.smp);
                        chk("period_rd_addr", st_addr, e.addr);
                        chk("period_wrap", st_wrap, e.wrp);
                        chk("period_hi_cnt", hi_cnt, e.smp);
                        if (e.smp != 8'h00) begin
                            chk("period_hi_first", hi_first, 1);
                            chk("period_hi_last", hi_last, e.smp);
                        end
                    end
                end
                started  = 1'b1;
                play_all = playing_a;
                st_smp   = sample_a;
                st_addr  = rd_addr_a;
                st_wrap  = wrap_a;
                hi_cnt   = 0;
                hi_first = -1;
                hi_last  = -1;
                offs     = 0;
            end else begin
                offs++;
                play_all = play_all & playing_a;
            end
            if (pwm_out_a) begin
                hi_cnt++;
                if (hi_first < 0) hi_first = offs;
                hi_last = offs;
            end
        end
    end

    initial begin
        int cyc, npe, bad, hi;
        int pe_at[3];
        rst_n = 1'b0; en_a = 1'b1; rr_a = 1'b0; en_b = 1'b0; rr_b = 1'b0;
        npe = 0; bad = 0; pe_at[0] = 0; pe_at[1] = 0; pe_at[2] = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {pwm_out_a, pw_end_a, playing_a, wrap_a, done_a, rd_addr_a, sample_a}, 0);
        rst_n = 1'b1;

        // Loader still filling: pw_end must keep its cadence, everything else quiet
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (pw_end_a) begin
                if (npe < 3) pe_at[npe] = c;
                npe++;
            end
            if (pwm_out_a || playing_a || (rd_addr_a != '0) || done_a || wrap_a) bad++;
        end
        chk("idle_pe0", pe_at[0], 256);
        chk("idle_pe1", pe_at[1], 512);
        chk("idle_pe2", pe_at[2], 768);
        chk("idle_pe_count", npe, 3);
        chk("idle_quiet", bad, 0);

        // First run, aborted at pwm_cnt=100 of the 0xFF period
        wait_pe(1, cyc);
        repeat (50) @(negedge clk);
        push_periods(6);
        rr_a = 1'b1;
        @(negedge clk);
        chk("arm_not_playing", playing_a, 0);
        wait_pe(7, cyc);
        repeat (100) @(negedge clk);
        chk("pre_abort_pwm", pwm_out_a, 1);
        chk("pre_abort_sample", sample_a, 8'hFF);
        rr_a = 1'b0;
        @(negedge clk);
        chk("abort_state", {playing_a, pwm_out_a, wrap_a, rd_addr_a, sample_a}, 0);
        wait_pe(1, cyc);
        chk("pe_cadence", 101 + cyc, 256);

        // Single-pass player
        repeat (30) @(negedge clk);
        en_b = 1'b1; rr_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_pe(1, cyc);
            chk("b_sample", sample_b, k);
            chk("b_playing", playing_b, 1);
            chk("b_rd_addr", rd_addr_b, (k + 1) % 4);
        end
        wait_pe(1, cyc);
        chk("b_done", {done_b, playing_b, rd_addr_b, sample_b}, {1'b1, 1'b0, 14'd0, 8'd0});
        hi = 0;
        repeat (300) begin
            @(negedge clk);
            if (pwm_out_b || !done_b) hi++;
        end
        chk("b_done_quiet", hi, 0);
        en_b = 1'b0;
        @(negedge clk);
        chk("b_done_clear", {done_b, playing_b}, 0);
        repeat (10) @(negedge clk);
        en_b = 1'b1;
        wait_pe(1, cyc);
        chk("b_replay0", {playing_b, rd_addr_b, sample_b}, {1'b1, 14'd1, 8'd0});
        wait_pe(1, cyc);
        chk("b_replay1", {playing_b, rd_addr_b, sample_b}, {1'b1, 14'd2, 8'd1});
        en_b = 1'b0;

        // Second run loops through the wrap, then an asynchronous reset mid-play
        repeat (20) @(negedge clk);
        push_periods(10);
        rr_a = 1'b1;
        wait_pe(11, cyc);
        chk("pre_reset", {playing_a, pw_end_a, rd_addr_a, sample_a}, {1'b1, 1'b1, 14'd3, 8'd2});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {pwm_out_a, pw_end_a, playing_a, wrap_a, done_a, rd_addr_a, sample_a}, 0);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("wrap_pulses", wrap_hi, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
